biquad_coef_loader: RTL
=======================

Name: biquad_coef_loader

Overview:
- Producer side of the biquad coefficient interface.
- Accepts a serial stream of 16-bit coefficient words over a valid/ready handshake and assembles them in shadow registers for N cascaded biquad sections.
- Commits the complete set atomically to the active coefficient outputs (b_0, b_1, b_2, a_1, a_2 per section) on a sample boundary. Filter sections therefore never see a mixed old/new coefficient set.
- Sits between the host/config path and the Chebyshev-II biquad cascade.

Parameters:
- N_SECTIONS, 4, number of cascaded biquad sections served.
- RESET_B0, 16'sh4000, reset/default value of every section's b_0 (unity in Q2.14). All other coefficients reset to 0, giving passthrough.

Ports:
- CLK  input  1  clock; all logic rising-edge.
- RST  input  1  synchronous active-high reset.
- load_start  input  1  one-cycle pulse; begins a new coefficient frame.
- load_valid  input  1  load_data holds a valid word.
- load_data  input  16  signed coefficient word.
- load_ready  output  1  loader accepts a word this cycle.
- sample_tick  input  1  one-cycle strobe at each filter sample boundary.
- coef_b0  output  16*N_SECTIONS  active b_0; section k at [16k+15:16k]. Same packing applies to coef_b1, coef_b2, coef_a1 and coef_a2.
- coef_b1  output  16*N_SECTIONS  active b_1.
- coef_b2  output  16*N_SECTIONS  active b_2.
- coef_a1  output  16*N_SECTIONS  active a_1.
- coef_a2  output  16*N_SECTIONS  active a_2.
- pending  output  1  full frame held in shadow, awaiting commit.
- committed  output  1  one-cycle pulse; new coefficients visible this cycle.
- abort_err  output  1  sticky; a frame was restarted or aborted mid-load.

Behaviour:
- Reset, synchronous, when RST=1 at an edge:
  - state=IDLE, word counter=0.
  - All shadow and active coefficients = 0, except every b_0 = RESET_B0.
  - load_ready=0, pending=0, committed=0, abort_err=0.
  - Reset mid-load or while PENDING discards everything.
- Frame format: 5*N_SECTIONS words, section-major. Order is s0.b0, s0.b1, s0.b2, s0.a1, s0.a2, s1.b0, and so on.
- Word index w maps to section w/5 and coefficient w%5.
- Transfer occurs on an edge with load_valid & load_ready.
- load_ready is registered and equals (state==LOAD). load_data is not inspected when no transfer occurs.
- FSM:
  - IDLE:
    - load_ready=0.
    - load_start -> LOAD with counter=0.
    - sample_tick is ignored.
  - LOAD:
    - Each transfer writes the shadow slot at the current counter, then counter+1.
    - Transfer of the last word (counter = 5*N_SECTIONS-1) -> PENDING, counter=0.
    - load_start in LOAD -> stay in LOAD, counter=0; a word offered that cycle is NOT accepted.
    - abort_err is set if counter!=0 at that load_start.
  - PENDING:
    - load_ready=0, pending=1.
    - On an edge with sample_tick=1: all active outputs <- shadow in one edge, state -> IDLE, committed=1 for the following cycle only.
    - load_start in PENDING (with or without sample_tick): no commit, -> LOAD with counter=0, abort_err set.
- Latency:
  - Last accepted word at edge E -> pending=1 from E.
  - Commit no earlier than the first sample_tick edge after E.
  - New active values and committed are visible in the same cycle.
- Active outputs change only at commit or reset. Partial frames never alter them.
- Shadow registers persist after commit. Unwritten shadow slots are impossible, since a commit requires a complete frame.
- sample_tick while not PENDING has no effect.
- Counter width is $clog2(5*N_SECTIONS); counter never wraps past the last index.

Test Plan:
- Reset, then no load -> every coef_b0 slice = 16'h4000; all others 0; load_ready=0; pending=0; abort_err=0.
- N=4:
  - Stimulus: load_start, then 20 back-to-back words 16'h0001..16'h0014 with load_valid=1.
  - pending rises after word 20. Outputs are unchanged until sample_tick.
  - At sample_tick: coef_b0[15:0]=1, coef_a2[15:0]=5, coef_b0[31:16]=6, coef_a2[63:48]=20.
  - committed pulses exactly one cycle.
- Throttled valid: the same frame with load_valid toggling 1/0 gives an identical committed result. load_ready stays 1 throughout LOAD.
- Abort mid-load:
  - Stimulus: after 7 words, load_start, then a full frame of 16'h7FFF.
  - abort_err=1. The commit shows all 16'h7FFF; no words from the first attempt survive.
- PENDING collision: frame complete, then load_start and sample_tick on the same edge -> no commit, state LOAD, abort_err=1, outputs keep old values.
- Reset mid-operation: RST while PENDING -> outputs return to passthrough defaults. A later sample_tick causes no commit and no committed pulse.

Source files
------------

// File: rtl/biquad_coef_loader.sv
// biquad_coef_loader: assembles a serial coefficient frame in shadow
// registers and commits it atomically to the biquad cascade on a sample tick.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   load_start          pulse, starts (or restarts) a coefficient frame
//   load_valid/ready    word handshake; load_data is the signed word
//   sample_tick         filter sample boundary strobe
//   coef_b0..coef_a2    active coefficients, section k at [16k+15:16k]
//   pending             complete frame held in shadow, awaiting a tick
//   committed           one-cycle pulse, new coefficients visible
//   abort_err           sticky, a frame was restarted or aborted mid-load
module biquad_coef_loader #(
  parameter int                 N_SECTIONS = 4,
  parameter logic signed [15:0] RESET_B0   = 16'sh4000
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic signed [15:0]             load_data,
  output logic                           load_ready,
  input  logic                           sample_tick,
  output logic [16*N_SECTIONS-1:0]       coef_b0,
  output logic [16*N_SECTIONS-1:0]       coef_b1,
  output logic [16*N_SECTIONS-1:0]       coef_b2,
  output logic [16*N_SECTIONS-1:0]       coef_a1,
  output logic [16*N_SECTIONS-1:0]       coef_a2,
  output logic                           pending,
  output logic                           committed,
  output logic                           abort_err
);

  localparam int NW = 5 * N_SECTIONS;
  localparam int CW = $clog2(NW);
  localparam int VW = 16 * N_SECTIONS;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  // Shadow frame is flat, word w at [16w+15:16w], section-major order.
  function automatic logic [16*NW-1:0] shadow_default();
    logic [16*NW-1:0] r;
    r = '0;
    for (int w = 0; w < NW; w++) begin
      if (w % 5 == 0) r[16*w +: 16] = RESET_B0;
    end
    return r;
  endfunction

  localparam logic [16*NW-1:0] SH_RST = shadow_default();
  localparam logic [VW-1:0]    B0_RST = {N_SECTIONS{RESET_B0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [16*NW-1:0] shadow_q;
  logic [VW-1:0]    b0_q, b1_q, b2_q, a1_q, a2_q;
  logic             ready_q;
  logic             pend_q;
  logic             comm_q;
  logic             abort_q;
  logic             xfer;

  // A restart pulse takes priority over a word offered in the same cycle.
  assign xfer = (state_q == LOAD) & ready_q & load_valid & ~load_start;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= SH_RST;
      b0_q     <= B0_RST;
      b1_q     <= '0;
      b2_q     <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      ready_q  <= 1'b0;
      pend_q   <= 1'b0;
      comm_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      comm_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            if (cnt_q != '0) abort_q <= 1'b1;
            cnt_q <= '0;
          end else if (xfer) begin
            shadow_q[16*cnt_q +: 16] <= load_data;
            if (cnt_q == LAST) begin
              state_q <= PEND;
              cnt_q   <= '0;
              ready_q <= 1'b0;
              pend_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        PEND: begin
          if (load_start) begin
            abort_q <= 1'b1;
            state_q <= LOAD;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            pend_q  <= 1'b0;
          end else if (sample_tick) begin
            for (int k = 0; k < N_SECTIONS; k++) begin
              b0_q[16*k +: 16] <= shadow_q[16*(5*k+0) +: 16];
              b1_q[16*k +: 16] <= shadow_q[16*(5*k+1) +: 16];
              b2_q[16*k +: 16] <= shadow_q[16*(5*k+2) +: 16];
              a1_q[16*k +: 16] <= shadow_q[16*(5*k+3) +: 16];
              a2_q[16*k +: 16] <= shadow_q[16*(5*k+4) +: 16];
            end
            state_q <= IDLE;
            pend_q  <= 1'b0;
            comm_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = ready_q;
  assign pending    = pend_q;
  assign committed  = comm_q;
  assign abort_err  = abort_q;
  assign coef_b0    = b0_q;
  assign coef_b1    = b1_q;
  assign coef_b2    = b2_q;
  assign coef_a1    = a1_q;
  assign coef_a2    = a2_q;

endmodule
